ripple_carry_adder: RTL and testbench

Registered N-bit ripple-carry adder built from a chain of identical single-bit full-adder cells. Bit 0 takes an external carry-in and carries propagate bit-to-bit to a final carry-out. One result register stage captures the sum and status flags. It is the arithmetic leaf for small datapaths and is a standalone verification target. The default width is 4.

---
 rtl/ripple_carry_adder_pkg.sv | 18 +
 rtl/full_adder_cell.sv | 16 +
 rtl/ripple_carry_adder.sv | 71 +++++++
 tb/tb_ripple_carry_adder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ripple_carry_adder_pkg.sv
// Shared types for the registered ripple-carry adder: the status-flag bundle
// that travels alongside the sum through the result register.
package ripple_carry_adder_pkg;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
    } flags_t;

    localparam flags_t FLAGS_RESET = '0;

    // Two's-complement overflow: the carries into and out of the sign bit disagree.
    function automatic logic signed_overflow(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; one link of the ripple-carry chain. Purely combinational.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Registered N-bit ripple-carry adder: WIDTH chained full-adder cells feeding
// one result register that captures sum, carry-out, overflow and zero.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam logic [WIDTH-1:0] SUM_RESET = '0;

    // Valid-only handshake: operands are taken on any edge with in_valid=1 and
    // the result appears one cycle later with out_valid=1; there is no ready.

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;
    flags_t           w_flags;

    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    flags_t           r_flags;

    assign w_c[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        full_adder_cell u_fa (
            .a  (a[gi]),
            .b  (b[gi]),
            .ci (w_c[gi]),
            .s  (w_sum[gi]),
            .co (w_c[gi+1])
        );
    end

    // For WIDTH == 1 the carry into the sign bit is cin itself (w_c[0]).
    assign w_flags.cout     = w_c[WIDTH];
    assign w_flags.overflow = signed_overflow(w_c[WIDTH-1], w_c[WIDTH]);
    assign w_flags.zero     = (w_sum == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= SUM_RESET;
            r_flags <= FLAGS_RESET;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum   <= w_sum;
                r_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_valid;
    assign sum       = r_sum;
    assign cout      = r_flags.cout;
    assign overflow  = r_flags.overflow;
    assign zero      = r_flags.zero;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed bench for ripple_carry_adder at WIDTH=4: hand-computed vectors,
// hold/idle behaviour, an exhaustive sweep, and asynchronous reset mid-stream.
module tb_ripple_carry_adder;

    localparam int W  = 4;
    localparam int EW = W + 4;   // {valid, cout, overflow, zero, sum}

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc);
        @(negedge clk);
        in_valid = v;
        a        = va;
        b        = vb;
        cin      = vc;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [W-1:0] es,
                             input logic ec, input logic eo, input logic ez);
        check({tag, ".valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".sum"},   32'(sum),       32'(es));
        check({tag, ".cout"},  32'(cout),      32'(ec));
        check({tag, ".ovf"},   32'(overflow),  32'(eo));
        check({tag, ".zero"},  32'(zero),      32'(ez));
    endtask

    // Independent reference: integer add plus sign-bit rule for overflow.
    function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic mc);
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         ovf;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        s    = full[W-1:0];
        ovf  = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
        return {1'b1, full[W], ovf, (s == '0), s};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] got;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        #12;
        check_all("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed vectors.
        drive(1'b1, 4'd6, 4'd10, 1'b0);
        check_all("v6p10", 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4'd9, 4'd10, 1'b1);
        check_all("v9p10c", 1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 4'd6, 4'd5, 1'b0);
        check_all("v6p5", 1'b1, 4'd11, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 4'd9, 4'd5, 1'b1);
        check_all("v9p5c", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);

        // Idle cycle: valid drops, result holds even though operands change.
        drive(1'b0, 4'd3, 4'd3, 1'b1);
        check_all("idle", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);

        // Boundaries.
        drive(1'b1, 4'd0, 4'd0, 1'b0);
        check_all("zero", 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'd15, 4'd15, 1'b1);
        check_all("allones", 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);

        // Exhaustive back-to-back sweep, in_valid held high.
        for (int i = 0; i < 512; i++) begin
            logic [W-1:0] xa;
            logic [W-1:0] xb;
            logic         xc;
            xa = W'(i >> 5);
            xb = W'(i >> 1);
            xc = i[0];
            exp_q.push_back(model(xa, xb, xc));
            drive(1'b1, xa, xb, xc);
            e   = exp_q.pop_front();
            got = {out_valid, cout, overflow, zero, sum};
            check($sformatf("sweep a=%0d b=%0d c=%0d", xa, xb, xc), 32'(got), 32'(e));
        end

        // A few random vectors through the same model.
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            exp_q.push_back(model(ra, rb, rc));
            drive(1'b1, ra, rb, rc);
            e   = exp_q.pop_front();
            got = {out_valid, cout, overflow, zero, sum};
            check($sformatf("rand a=%0d b=%0d c=%0d", ra, rb, rc), 32'(got), 32'(e));
        end

        // Asynchronous reset mid-stream.
        drive(1'b1, 4'd7, 4'd8, 1'b0);
        check_all("prerst", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("asyncrst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("inrst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("postrst_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd15, 4'd15, 1'b1);
        check_all("postrst_first", 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
